// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin front end for one shared 32-bit barrel shifter.
// Accepts one request at a time, drives the external shifter from registered
// operands and returns the registered, ID-tagged result on one response channel.
// Optional feature macro: SHIFT_ARB_ROTATE_EN adds rotate, built from two
// shifter passes OR'd together in an extra SHIFT2 state.
module shifter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_dir,
    input  logic [NUM_REQ-1:0]    req_rot,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ*5-1:0]  req_amt,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  sh_dir,
    output logic [31:0]           sh_data,
    output logic [4:0]            sh_amt,
    input  logic [31:0]           sh_out
);

`ifdef SHIFT_ARB_ROTATE_EN
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift1 = 2'd1,
        StShift2 = 2'd2,
        StResp   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift1 = 2'd1,
        StResp   = 2'd3
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     acc_q, acc_d;
    logic            sh_dir_q, sh_dir_d;
    logic [31:0]     sh_data_q, sh_data_d;
    logic [4:0]      sh_amt_q, sh_amt_d;

`ifdef SHIFT_ARB_ROTATE_EN
    // Operands kept for the second rotate pass
    logic            dir_q, dir_d;
    logic            rot_q, rot_d;
    logic [31:0]     data_q, data_d;
    logic [4:0]      amt_q, amt_d;
`else
    logic            unused_rot;
    assign unused_rot = ^req_rot;
`endif

    // Per-requester operand views of the flattened buses
    logic [31:0] data_arr [NUM_REQ];
    logic [4:0]  amt_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[32*gi +: 32];
        assign amt_arr[gi]  = req_amt[5*gi +: 5];
    end

    logic [ID_W-1:0] grant;
    logic            any_valid;
    int              cand;

    // Round-robin pick: first valid requester at or above ptr, wrapping.
    // Scanning downward lets the lowest offset win without an early exit.
    always_comb begin
        grant     = ptr_q;
        any_valid = 1'b0;
        cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_valid[ID_W'(cand)]) begin
                grant     = ID_W'(cand);
                any_valid = 1'b1;
            end
        end
    end

    // Next-state, grant and datapath control
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        acc_d     = acc_q;
        sh_dir_d  = sh_dir_q;
        sh_data_d = sh_data_q;
        sh_amt_d  = sh_amt_q;
        req_ready = '0;
`ifdef SHIFT_ARB_ROTATE_EN
        dir_d     = dir_q;
        rot_d     = rot_q;
        data_d    = data_q;
        amt_d     = amt_q;
`endif
        case (state_q)
            StIdle: begin
                // Grant is suppressed during reset so ready reads as zero
                if (any_valid && !rst) begin
                    req_ready[grant] = 1'b1;
                    id_d      = grant;
                    sh_dir_d  = req_dir[grant];
                    sh_data_d = data_arr[grant];
                    sh_amt_d  = amt_arr[grant];
`ifdef SHIFT_ARB_ROTATE_EN
                    dir_d     = req_dir[grant];
                    rot_d     = req_rot[grant];
                    data_d    = data_arr[grant];
                    amt_d     = amt_arr[grant];
`endif
                    ptr_d     = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
                    state_d   = StShift1;
                end
            end
            StShift1: begin
                acc_d = sh_out;
`ifdef SHIFT_ARB_ROTATE_EN
                // Rotate = (x shifted by n) | (x shifted the other way by 32-n)
                if (rot_q && (amt_q != 5'd0)) begin
                    sh_dir_d  = ~dir_q;
                    sh_amt_d  = 5'd0 - amt_q;
                    sh_data_d = data_q;
                    state_d   = StShift2;
                end else begin
                    state_d = StResp;
                end
`else
                state_d = StResp;
`endif
            end
`ifdef SHIFT_ARB_ROTATE_EN
            StShift2: begin
                acc_d   = acc_q | sh_out;
                state_d = StResp;
            end
`endif
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            id_q      <= '0;
            acc_q     <= '0;
            sh_dir_q  <= 1'b0;
            sh_data_q <= '0;
            sh_amt_q  <= '0;
`ifdef SHIFT_ARB_ROTATE_EN
            dir_q     <= 1'b0;
            rot_q     <= 1'b0;
            data_q    <= '0;
            amt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            acc_q     <= acc_d;
            sh_dir_q  <= sh_dir_d;
            sh_data_q <= sh_data_d;
            sh_amt_q  <= sh_amt_d;
`ifdef SHIFT_ARB_ROTATE_EN
            dir_q     <= dir_d;
            rot_q     <= rot_d;
            data_q    <= data_d;
            amt_q     <= amt_d;
`endif
        end
    end

    assign resp_valid = (state_q == StResp);
    assign resp_data  = acc_q;
    assign resp_id    = id_q;
    assign sh_dir     = sh_dir_q;
    assign sh_data    = sh_data_q;
    assign sh_amt     = sh_amt_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: table-driven single-requester vectors, a
// round-robin burst, backpressure and mid-transaction reset sequences.
// Responses are checked against a queue of expected results.
module tb_shifter_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_dir;
    logic [NUM_REQ-1:0]    req_rot;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ*5-1:0]  req_amt;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic [ID_W-1:0]       resp_id;
    logic                  sh_dir;
    logic [31:0]           sh_data;
    logic [4:0]            sh_amt;
    logic [31:0]           sh_out;

    logic        op_dir  [NUM_REQ];
    logic        op_rot  [NUM_REQ];
    logic [31:0] op_data [NUM_REQ];
    logic [4:0]  op_amt  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
        assign req_dir[gi]            = op_dir[gi];
        assign req_rot[gi]            = op_rot[gi];
        assign req_data[32*gi +: 32]  = op_data[gi];
        assign req_amt[5*gi +: 5]     = op_amt[gi];
    end

    // Behavioural shared shifter
    assign sh_out = sh_dir ? (sh_data >> sh_amt) : (sh_data << sh_amt);

    shifter_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dir    (req_dir),
        .req_rot    (req_rot),
        .req_data   (req_data),
        .req_amt    (req_amt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .sh_dir     (sh_dir),
        .sh_data    (sh_data),
        .sh_amt     (sh_amt),
        .sh_out     (sh_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        int              cyc;
    } exp_t;

    typedef struct {
        int          id;
        bit          dir;
        bit          rot;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] expd;
        int          lat;
    } vec_t;

    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_shift(input bit dir, input logic [31:0] d,
                                              input logic [4:0] a);
        return dir ? (d >> a) : (d << a);
    endfunction

    // Response monitor: latency on rising resp_valid, data/id on accept
    initial begin
        exp_t e;
        bit   prev_v;
        bit   prev_acc;
        prev_v   = 1'b0;
        prev_acc = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                prev_v   = 1'b0;
                prev_acc = 1'b0;
            end else begin
                if (prev_acc) begin
                    chk("resp_valid after accept", {31'b0, resp_valid}, 32'd0);
                end
                if (resp_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        chk("resp_valid with empty scoreboard", {31'b0, resp_valid}, 32'd0);
                    end else begin
                        chk("resp latency", 32'(cyc), 32'(sb[0].cyc));
                    end
                end
                prev_acc = 1'b0;
                if (resp_valid && resp_ready) begin
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("resp_data", resp_data, e.data);
                        chk("resp_id", 32'(resp_id), 32'(e.id));
                    end
                    prev_acc = 1'b1;
                end
                prev_v = resp_valid;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after transfer
    task automatic issue(input int i, input bit dir, input bit rot, input logic [31:0] data,
                         input logic [4:0] amt, input logic [31:0] expd, input int lat);
        exp_t e;
        bit   got;
        got        = 1'b0;
        op_dir[i]  = dir;
        op_rot[i]  = rot;
        op_data[i] = data;
        op_amt[i]  = amt;
        req_valid  = NUM_REQ'(1) << i;
        #1;
        for (int c = 0; c < 10; c++) begin
            if ((req_valid & req_ready) != '0) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        chk("grant one-hot", 32'(req_ready), 32'(1) << i);
        if (got) begin
            e.id   = ID_W'(i);
            e.data = expd;
            e.cyc  = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            chk("response timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [$];
        exp_t e;
        int   order [5];
        int   k;
        int   last_cyc;
        int   g;

        order = '{0, 1, 2, 3, 0};
        vecs.push_back('{id: 0, dir: 0, rot: 0, data: 32'd30000,      amt: 5'd1,
                         expd: 32'd60000,      lat: 2});
        vecs.push_back('{id: 1, dir: 1, rot: 0, data: 32'h0000_0001, amt: 5'd1,
                         expd: 32'h0000_0000, lat: 2});
        vecs.push_back('{id: 2, dir: 0, rot: 0, data: 32'hFFFF_FFFF, amt: 5'd31,
                         expd: 32'h8000_0000, lat: 2});
        vecs.push_back('{id: 3, dir: 1, rot: 0, data: 32'hF000_0000, amt: 5'd28,
                         expd: 32'h0000_000F, lat: 2});
        vecs.push_back('{id: 1, dir: 0, rot: 0, data: 32'h1234_5678, amt: 5'd0,
                         expd: 32'h1234_5678, lat: 2});
        vecs.push_back('{id: 2, dir: 1, rot: 0, data: 32'h8000_0000, amt: 5'd31,
                         expd: 32'h0000_0001, lat: 2});
`ifdef SHIFT_ARB_ROTATE_EN
        vecs.push_back('{id: 3, dir: 0, rot: 1, data: 32'h8000_0001, amt: 5'd4,
                         expd: 32'h0000_0018, lat: 3});
        vecs.push_back('{id: 0, dir: 0, rot: 1, data: 32'h1234_5678, amt: 5'd0,
                         expd: 32'h1234_5678, lat: 2});
        vecs.push_back('{id: 1, dir: 1, rot: 1, data: 32'h0000_0001, amt: 5'd4,
                         expd: 32'h1000_0000, lat: 3});
`else
        // Rotate select is ignored: plain left shift
        vecs.push_back('{id: 3, dir: 0, rot: 1, data: 32'h8000_0001, amt: 5'd4,
                         expd: 32'h0000_0010, lat: 2});
`endif

        for (int i = 0; i < NUM_REQ; i++) begin
            op_dir[i]  = 1'b0;
            op_rot[i]  = 1'b0;
            op_data[i] = '0;
            op_amt[i]  = '0;
        end

        // Reset with requests pending: nothing granted, outputs at reset values
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset resp_data", resp_data, 32'd0);
        chk("reset resp_id", 32'(resp_id), 32'd0);
        chk("reset sh_dir", {31'b0, sh_dir}, 32'd0);
        chk("reset sh_data", sh_data, 32'd0);
        chk("reset sh_amt", 32'(sh_amt), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin burst with all requesters valid
        for (int i = 0; i < NUM_REQ; i++) begin
            op_dir[i]  = i[0];
            op_rot[i]  = 1'b0;
            op_data[i] = 32'hA5C3_0F00 + 32'(i * 17);
            op_amt[i]  = 5'(i + 1);
        end
        resp_ready = 1'b1;
        req_valid  = '1;
        #1;
        k        = 0;
        last_cyc = 0;
        for (int c = 0; c < 40; c++) begin
            if (req_ready != '0) begin
                chk("rr grant", 32'(req_ready), 32'(1) << order[k]);
                if (k > 0) begin
                    chk("rr issue interval", 32'(cyc - last_cyc), 32'd3);
                end
                last_cyc = cyc;
                g        = order[k];
                e.id     = ID_W'(g);
                e.data   = ref_shift(op_dir[g], op_data[g], op_amt[g]);
                e.cyc    = cyc + 1 + 2;
                sb.push_back(e);
                k++;
                if (k == 5) begin
                    break;
                end
            end
            @(posedge clk);
            #2;
        end
        chk("rr grant count", 32'(k), 32'd5);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain(20);

        // Table vectors, one requester at a time
        foreach (vecs[i]) begin
            issue(vecs[i].id, vecs[i].dir, vecs[i].rot, vecs[i].data, vecs[i].amt,
                  vecs[i].expd, vecs[i].lat);
            wait_drain(20);
        end

        // Backpressure: result held, no grants while resp_ready is low
        resp_ready = 1'b0;
        issue(0, 1'b0, 1'b0, 32'h0000_00FF, 5'd8, 32'h0000_FF00, 2);
        #1;
        for (int c = 0; c < 10 && !resp_valid; c++) begin
            @(posedge clk);
            #2;
        end
        op_data[2] = 32'h0000_0003;
        op_amt[2]  = 5'd1;
        req_valid  = 4'b0100;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp resp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp resp_data", resp_data, 32'h0000_FF00);
            chk("bp resp_id", 32'(resp_id), 32'd0);
            chk("bp req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #3;
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(posedge clk);
        #2;
        chk("bp accepted", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Reset during SHIFT1: response discarded, pointer back to 0
        issue(2, 1'b1, 1'b0, 32'hDEAD_BEEF, 5'd4, 32'h0DEA_DBEE, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid-rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid-rst resp_data", resp_data, 32'd0);
        chk("mid-rst resp_id", 32'(resp_id), 32'd0);
        chk("mid-rst sh_dir", {31'b0, sh_dir}, 32'd0);
        chk("mid-rst sh_data", sh_data, 32'd0);
        chk("mid-rst sh_amt", 32'(sh_amt), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            op_dir[i]  = 1'b1;
            op_data[i] = 32'h0000_0100 << i;
            op_amt[i]  = 5'd2;
        end
        req_valid = '1;
        #1;
        chk("post-rst grant", 32'(req_ready), 32'd1);
        if (req_ready == 4'b0001) begin
            e.id   = '0;
            e.data = 32'h0000_0040;
            e.cyc  = cyc + 1 + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
